// File: rtl/reg_file_staged.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_file_staged                                               |
// | Purpose  : Parametrised 2R+debug register file with a one-entry write    |
// |            staging register, optional read bypass and post-reset clear.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module reg_file_staged #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 1,
    parameter int NUM_REGS = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              ready,
    output logic              wr_drop
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_clr_last = ADDR_W'(NUM_REGS - 1);
    localparam int                c_nports   = 3;

    function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < 32'(NUM_REGS);
    endfunction

    function automatic logic f_is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic                r_ready;
    logic                r_wr_drop;
    logic                r_stg_valid;
    logic [ADDR_W-1:0]   r_stg_addr;
    logic [DATA_W-1:0]   r_stg_data;
    logic [DATA_W-1:0]   r_mem [NUM_REGS];

    logic                w_clr_last;
    logic                w_accept;
    logic                w_reject;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_din;

    assign w_clr_last = (r_state == ST_CLEAR) && (r_clr_ptr == c_clr_last);
    assign w_accept   = (r_state == ST_READY) && we && f_in_range(waddr) && !f_is_zero(waddr);
    assign w_reject   = we && !w_accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (w_clr_last) w_state_nxt = ST_READY;
            ST_READY: w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clr_ptr   <= '0;
            r_stg_valid <= 1'b0;
            r_ready     <= 1'b0;
            r_wr_drop   <= 1'b0;
        end else begin
            r_wr_drop   <= w_reject;
            r_stg_valid <= w_accept;
            if (r_state == ST_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
                if (w_clr_last) r_ready <= 1'b1;
            end
        end
    end

    // Staging payload needs no reset: it is qualified by r_stg_valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_stg_addr <= waddr;
            r_stg_data <= wdata;
        end
    end

    // Single array write port shared by the clear pass and staged commits;
    // gating on rst_n keeps a pending commit from landing during reset.
    assign w_mem_we   = rst_n && ((r_state == ST_CLEAR) || r_stg_valid);
    assign w_mem_addr = (r_state == ST_CLEAR) ? r_clr_ptr : r_stg_addr;
    assign w_mem_din  = (r_state == ST_CLEAR) ? '0 : r_stg_data;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_din;
    end

    logic [ADDR_W-1:0] w_rd_addr [c_nports];
    logic [DATA_W-1:0] w_rd_data [c_nports];

    assign w_rd_addr[0] = raddr1;
    assign w_rd_addr[1] = raddr2;
    assign w_rd_addr[2] = dbg_addr;

    generate
        for (genvar gi = 0; gi < c_nports; gi++) begin : g_rd_port
            assign w_rd_data[gi] =
                (r_state != ST_READY)                 ? '0 :
                !f_in_range(w_rd_addr[gi])            ? '0 :
                f_is_zero(w_rd_addr[gi])              ? '0 :
                ((BYPASS != 0) && r_stg_valid &&
                 (w_rd_addr[gi] == r_stg_addr))       ? r_stg_data :
                                                        r_mem[w_rd_addr[gi]];
        end
    endgenerate

    assign rdata1   = w_rd_data[0];
    assign rdata2   = w_rd_data[1];
    assign dbg_data = w_rd_data[2];
    assign ready    = r_ready;
    assign wr_drop  = r_wr_drop;

endmodule
`default_nettype wire
